// File: rtl/register_file_mp.sv
// Parametrised multi-read-port register file with a post-reset hardware clear
// and a 4-phase debug access port (req/ack) for the debug/loader controller.
module register_file_mp #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int NREAD   = 2,
  parameter int ZERO_X0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       di,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] qa,
  output logic                  busy,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [AW-1:0]         dbg_addr,
  input  logic [XLEN-1:0]       dbg_wdata,
  output logic                  dbg_ack,
  output logic [XLEN-1:0]       dbg_rdata
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {CLEAR, IDLE, DONE} state_e;

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic            busy_q;
  logic            dbg_ack_q;
  logic [XLEN-1:0] dbg_rdata_q;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic core_wr;
  logic dbg_zero;
  logic dbg_wr;

  assign core_wr  = (state_q != CLEAR) && we && !((ZERO_X0 != 0) && (rd == '0));
  assign dbg_zero = (ZERO_X0 != 0) && (dbg_addr == '0);
  assign dbg_wr   = (state_q == IDLE) && dbg_req && dbg_we && !dbg_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      busy_q      <= 1'b1;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == {AW{1'b1}}) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (dbg_req) begin
            state_q     <= DONE;
            dbg_ack_q   <= 1'b1;
            // Reads see the pre-edge array value; writes echo the written data.
            dbg_rdata_q <= dbg_we ? dbg_wdata : (dbg_zero ? '0 : mem_q[dbg_addr]);
          end
        end
        DONE: begin
          if (!dbg_req) begin
            state_q   <= IDLE;
            dbg_ack_q <= 1'b0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Debug write is ordered after the core write so it wins on an address clash.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else begin
        if (core_wr) mem_q[rd] <= di;
        if (dbg_wr) mem_q[dbg_addr] <= dbg_wdata;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;

      assign addr = ra[gi*AW +: AW];

      always_comb begin
        data = mem_q[addr];
        if (state_q == CLEAR) begin
          data = '0;
        end else if ((ZERO_X0 != 0) && (addr == '0)) begin
          data = '0;
        end else if ((BYPASS != 0) && we && (rd == addr)) begin
          data = di;
        end
      end

      assign qa[gi*XLEN +: XLEN] = data;
    end
  endgenerate

  assign busy      = busy_q;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule
